cpu_writeback: RTL and testbench



---
 rtl/cpu_writeback_pkg.sv | 22 ++
 rtl/cpu_stack_ram.sv | 32 +++
 rtl/cpu_writeback.sv | 152 +++++++++++++++
 tb/tb_cpu_writeback.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_writeback_pkg.sv
// Purpose: shared opcode codes, widths and the stack entry type for the writeback stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: TYPE_W/DATA_W/STACK_ENTRY_W widths, UC_PUSH* push selects, stack_entry_t.
package cpu_writeback_pkg;

   localparam int TYPE_W        = 3;
   localparam int DATA_W        = 32;
   localparam int STACK_ENTRY_W = TYPE_W + DATA_W;

   // Push selects; UC_PUSHNONE marks a slot that pushes nothing.
   localparam logic [2:0] UC_PUSHNONE = 3'd0;
   localparam logic [2:0] UC_PUSHALU  = 3'd1;
   localparam logic [2:0] UC_PUSHMEM  = 3'd2;
   localparam logic [2:0] UC_PUSHLIT  = 3'd3;

   typedef struct packed {
      logic [TYPE_W-1:0] typ;
      logic [DATA_W-1:0] dat;
   } stack_entry_t;

endpackage

// File: rtl/cpu_stack_ram.sv
// Purpose: operand-stack storage, DEPTH x W registers, one write port, two async read ports.
// Latency: write lands at the clock edge; reads are combinational.
// Backpressure: none; the caller qualifies wr_en.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_a_addr/rd_a_dat and rd_b_addr/rd_b_dat reads.
module cpu_stack_ram #(
   parameter int DEPTH = 64,
   parameter int W     = 35,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_dat,
   input  logic [AW-1:0] rd_a_addr,
   output logic [W-1:0]  rd_a_dat,
   input  logic [AW-1:0] rd_b_addr,
   output logic [W-1:0]  rd_b_dat
);

   // Contents are deliberately not reset; the stack pointer masks stale entries.
   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_dat;
      end
   end

   assign rd_a_dat = mem_q[rd_a_addr];
   assign rd_b_dat = mem_q[rd_b_addr];

endmodule

// File: rtl/cpu_writeback.sv
// Purpose: final stage; commits pop-then-push to the operand stack, drives fetch redirect, kill shadow.
// Latency: all *_5a outputs are registered, 1 cycle after the stage-4 inputs.
// Backpressure: none; every stage-4 slot is consumed each cycle (non-live slots are discarded).
// Ports: clk, rst_b; stage-4 pc/kill/branch_target/pop/push/select in;
//        redirect, redirect_target, tos, nos, sp, retired_pc, underflow, overflow out.
module cpu_writeback
   import cpu_writeback_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int SP_W        = 11,
   parameter int KILL_SHADOW = 3
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic [31:0]              pc_4a,
   input  logic                     kill_4a,
   input  logic [31:0]              branch_target_4a,
   input  logic [10:0]              st__to_pop_4a,
   input  logic [STACK_ENTRY_W-1:0] st__to_push_4a,
   input  logic [2:0]               c__to_push_4a,
   output logic                     redirect_5a,
   output logic [31:0]              redirect_target_5a,
   output logic [STACK_ENTRY_W-1:0] tos_5a,
   output logic [STACK_ENTRY_W-1:0] nos_5a,
   output logic [SP_W-1:0]          sp_5a,
   output logic [31:0]              retired_pc_5a,
   output logic                     underflow_5a,
   output logic                     overflow_5a
);

   localparam int AW    = $clog2(DEPTH);
   localparam int EXT_W = 12;
   localparam int SH_W  = $clog2(KILL_SHADOW + 1);
   localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(DEPTH);

   logic [SP_W-1:0]  sp_q, sp_d, sp_mid, sp_next;
   logic [EXT_W-1:0] sp_ext, pop_ext;
   logic [SH_W-1:0]  shadow_q, shadow_d;
   logic             redirect_q, redirect_d;
   logic [31:0]      redirect_target_q, redirect_target_d;
   logic [31:0]      retired_pc_q, retired_pc_d;
   logic             underflow_q, underflow_d;
   logic             overflow_q, overflow_d;
   stack_entry_t     tos_q, tos_d, nos_q, nos_d;
   stack_entry_t     push_dat, rd_a_dat, rd_b_dat;
   logic             live, push_sel, push_ok, underflow_now, overflow_now, wr_en;
   logic [AW-1:0]    wr_addr, rd_a_addr, rd_b_addr;

   assign push_dat = st__to_push_4a;
   assign live     = (shadow_q == '0);

   // Pointer arithmetic: compare at 12 bits so a large pop never wraps; the
   // subtraction itself is only used when pop <= sp, so it fits in SP_W.
   always_comb begin
      sp_ext        = EXT_W'(sp_q);
      pop_ext       = EXT_W'(st__to_pop_4a);
      underflow_now = (pop_ext > sp_ext);
      sp_mid        = underflow_now ? '0 : (sp_q - SP_W'(st__to_pop_4a));
      push_sel      = (c__to_push_4a != UC_PUSHNONE);
      push_ok       = push_sel && (sp_mid < DEPTH_SP);
      overflow_now  = push_sel && !push_ok;
      sp_next       = push_ok ? (sp_mid + SP_W'(1)) : sp_mid;
      wr_en         = live && push_ok;
      wr_addr       = AW'(sp_mid);
      // Index arithmetic may wrap when sp_mid < 2; those reads are masked below.
      rd_a_addr     = AW'(sp_mid - SP_W'(1));
      rd_b_addr     = AW'(sp_mid - SP_W'(2));
   end

   cpu_stack_ram #(
      .DEPTH (DEPTH),
      .W     (STACK_ENTRY_W),
      .AW    (AW)
   ) u_stack_ram (
      .clk       (clk),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_dat    (push_dat),
      .rd_a_addr (rd_a_addr),
      .rd_a_dat  (rd_a_dat),
      .rd_b_addr (rd_b_addr),
      .rd_b_dat  (rd_b_dat)
   );

   always_comb begin
      sp_d              = sp_q;
      tos_d             = tos_q;
      nos_d             = nos_q;
      shadow_d          = shadow_q;
      redirect_d        = 1'b0;
      redirect_target_d = redirect_target_q;
      retired_pc_d      = retired_pc_q;
      underflow_d       = underflow_q;
      overflow_d        = overflow_q;
      if (live) begin
         sp_d         = sp_next;
         retired_pc_d = pc_4a;
         underflow_d  = underflow_q | underflow_now;
         overflow_d   = overflow_q | overflow_now;
         if (push_ok) begin
            // Bypass the pushed value; the old top (sp_mid-1) becomes next-of-stack.
            tos_d = push_dat;
            nos_d = (sp_mid != '0) ? rd_a_dat : '0;
         end else begin
            tos_d = (sp_mid != '0) ? rd_a_dat : '0;
            nos_d = (sp_mid > SP_W'(1)) ? rd_b_dat : '0;
         end
         if (kill_4a) begin
            redirect_d        = 1'b1;
            redirect_target_d = branch_target_4a;
            shadow_d          = SH_W'(KILL_SHADOW);
         end
      end else begin
         // Wrong-path slot: burn one shadow count, ignore everything it carries.
         shadow_d = shadow_q - SH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         sp_q              <= '0;
         tos_q             <= '0;
         nos_q             <= '0;
         shadow_q          <= '0;
         redirect_q        <= 1'b0;
         redirect_target_q <= '0;
         retired_pc_q      <= '0;
         underflow_q       <= 1'b0;
         overflow_q        <= 1'b0;
      end else begin
         sp_q              <= sp_d;
         tos_q             <= tos_d;
         nos_q             <= nos_d;
         shadow_q          <= shadow_d;
         redirect_q        <= redirect_d;
         redirect_target_q <= redirect_target_d;
         retired_pc_q      <= retired_pc_d;
         underflow_q       <= underflow_d;
         overflow_q        <= overflow_d;
      end
   end

   assign sp_5a              = sp_q;
   assign tos_5a             = tos_q;
   assign nos_5a             = nos_q;
   assign redirect_5a        = redirect_q;
   assign redirect_target_5a = redirect_target_q;
   assign retired_pc_5a      = retired_pc_q;
   assign underflow_5a       = underflow_q;
   assign overflow_5a        = overflow_q;

endmodule

// File: tb/tb_cpu_writeback.sv
// Purpose: directed self-checking bench for cpu_writeback.
// Latency: checks outputs 1 ns after the commit edge.
// Backpressure: n/a.
module tb_cpu_writeback;
   import cpu_writeback_pkg::*;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [31:0] pc_4a;
   logic        kill_4a;
   logic [31:0] branch_target_4a;
   logic [10:0] st__to_pop_4a;
   logic [34:0] st__to_push_4a;
   logic [2:0]  c__to_push_4a;
   logic        redirect_5a;
   logic [31:0] redirect_target_5a;
   logic [34:0] tos_5a;
   logic [34:0] nos_5a;
   logic [10:0] sp_5a;
   logic [31:0] retired_pc_5a;
   logic        underflow_5a;
   logic        overflow_5a;

   int checks = 0;
   int errors = 0;

   cpu_writeback #(.DEPTH(64), .SP_W(11), .KILL_SHADOW(3)) dut (
      .clk                (clk),
      .rst_b              (rst_b),
      .pc_4a              (pc_4a),
      .kill_4a            (kill_4a),
      .branch_target_4a   (branch_target_4a),
      .st__to_pop_4a      (st__to_pop_4a),
      .st__to_push_4a     (st__to_push_4a),
      .c__to_push_4a      (c__to_push_4a),
      .redirect_5a        (redirect_5a),
      .redirect_target_5a (redirect_target_5a),
      .tos_5a             (tos_5a),
      .nos_5a             (nos_5a),
      .sp_5a              (sp_5a),
      .retired_pc_5a      (retired_pc_5a),
      .underflow_5a       (underflow_5a),
      .overflow_5a        (overflow_5a)
   );

   always #5 clk = ~clk;

   // Present one stage-4 slot, let it commit, then return the inputs to idle.
   task automatic op(input logic [10:0] pop, input logic [2:0] sel, input logic [34:0] val,
                     input logic kill, input logic [31:0] tgt, input logic [31:0] pc);
      st__to_pop_4a    = pop;
      c__to_push_4a    = sel;
      st__to_push_4a   = val;
      kill_4a          = kill;
      branch_target_4a = tgt;
      pc_4a            = pc;
      @(posedge clk);
      #1;
      st__to_pop_4a    = '0;
      c__to_push_4a    = UC_PUSHNONE;
      kill_4a          = 1'b0;
   endtask

   task automatic test_reset();
      rst_b = 1'b0; pc_4a = '0; kill_4a = 1'b0; branch_target_4a = '0;
      st__to_pop_4a = '0; st__to_push_4a = '0; c__to_push_4a = UC_PUSHNONE;
      #2;
      checks++; if (sp_5a !== 11'd0) begin errors++; $display("FAIL reset_sp got %0d want 0", sp_5a); end
      checks++; if (tos_5a !== 35'd0 || nos_5a !== 35'd0) begin errors++; $display("FAIL reset_tos_nos got %h/%h want 0/0", tos_5a, nos_5a); end
      checks++; if (redirect_5a !== 1'b0 || redirect_target_5a !== 32'd0) begin errors++; $display("FAIL reset_redirect got %b/%h want 0/0", redirect_5a, redirect_target_5a); end
      checks++; if (retired_pc_5a !== 32'd0 || underflow_5a !== 1'b0 || overflow_5a !== 1'b0) begin errors++; $display("FAIL reset_misc got pc=%h uf=%b of=%b want 0", retired_pc_5a, underflow_5a, overflow_5a); end
      @(posedge clk); #3;
      rst_b = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_push();
      op(11'd0, UC_PUSHALU, 35'h1_0000_0005, 1'b0, 32'd0, 32'h10);
      checks++; if (sp_5a !== 11'd1) begin errors++; $display("FAIL push1_sp got %0d want 1", sp_5a); end
      checks++; if (tos_5a !== 35'h1_0000_0005 || nos_5a !== 35'd0) begin errors++; $display("FAIL push1_tos_nos got %h/%h want 100000005/0", tos_5a, nos_5a); end
      checks++; if (retired_pc_5a !== 32'h10) begin errors++; $display("FAIL push1_pc got %h want 10", retired_pc_5a); end
      op(11'd0, UC_PUSHALU, 35'h1_0000_0007, 1'b0, 32'd0, 32'h14);
      checks++; if (sp_5a !== 11'd2) begin errors++; $display("FAIL push2_sp got %0d want 2", sp_5a); end
      checks++; if (tos_5a !== 35'h1_0000_0007) begin errors++; $display("FAIL push2_tos got %h want 100000007", tos_5a); end
      checks++; if (nos_5a !== 35'h1_0000_0005) begin errors++; $display("FAIL push2_nos got %h want 100000005", nos_5a); end
   endtask

   task automatic test_pop_push();
      op(11'd0, UC_PUSHMEM, 35'h2_0000_0009, 1'b0, 32'd0, 32'h18);
      checks++; if (sp_5a !== 11'd3 || tos_5a !== 35'h2_0000_0009) begin errors++; $display("FAIL push3 got sp=%0d tos=%h want 3/200000009", sp_5a, tos_5a); end
      op(11'd2, UC_PUSHALU, 35'h0AA, 1'b0, 32'd0, 32'h1C);
      checks++; if (sp_5a !== 11'd2) begin errors++; $display("FAIL poppush_sp got %0d want 2", sp_5a); end
      checks++; if (tos_5a !== 35'h0AA) begin errors++; $display("FAIL poppush_tos got %h want 0aa", tos_5a); end
      checks++; if (nos_5a !== 35'h1_0000_0005) begin errors++; $display("FAIL poppush_nos got %h want 100000005", nos_5a); end
      op(11'd1, UC_PUSHNONE, 35'd0, 1'b0, 32'd0, 32'h20);
      checks++; if (sp_5a !== 11'd1 || tos_5a !== 35'h1_0000_0005 || nos_5a !== 35'd0) begin errors++; $display("FAIL pop1 got sp=%0d tos=%h nos=%h want 1/100000005/0", sp_5a, tos_5a, nos_5a); end
   endtask

   task automatic test_underflow();
      op(11'd5, UC_PUSHNONE, 35'd0, 1'b0, 32'd0, 32'h24);
      checks++; if (sp_5a !== 11'd0 || tos_5a !== 35'd0 || nos_5a !== 35'd0) begin errors++; $display("FAIL uf_state got sp=%0d tos=%h nos=%h want 0/0/0", sp_5a, tos_5a, nos_5a); end
      checks++; if (underflow_5a !== 1'b1) begin errors++; $display("FAIL uf_flag got %b want 1", underflow_5a); end
      checks++; if (overflow_5a !== 1'b0) begin errors++; $display("FAIL uf_no_of got %b want 0", overflow_5a); end
      op(11'd0, UC_PUSHMEM, 35'h033, 1'b0, 32'd0, 32'h28);
      checks++; if (sp_5a !== 11'd1 || tos_5a !== 35'h033 || underflow_5a !== 1'b1) begin errors++; $display("FAIL uf_sticky1 got sp=%0d tos=%h uf=%b want 1/033/1", sp_5a, tos_5a, underflow_5a); end
      op(11'd1, UC_PUSHNONE, 35'd0, 1'b0, 32'd0, 32'h2C);
      checks++; if (sp_5a !== 11'd0 || underflow_5a !== 1'b1) begin errors++; $display("FAIL uf_sticky2 got sp=%0d uf=%b want 0/1", sp_5a, underflow_5a); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 64; i++) begin
         op(11'd0, UC_PUSHALU, {3'd1, 32'(i)}, 1'b0, 32'd0, 32'(32'h1000 + i * 4));
      end
      checks++; if (sp_5a !== 11'd64) begin errors++; $display("FAIL fill_sp got %0d want 64", sp_5a); end
      checks++; if (tos_5a !== 35'h1_0000_003F || nos_5a !== 35'h1_0000_003E) begin errors++; $display("FAIL fill_tos_nos got %h/%h want 10000003f/10000003e", tos_5a, nos_5a); end
      checks++; if (overflow_5a !== 1'b0) begin errors++; $display("FAIL fill_no_of got %b want 0", overflow_5a); end
      op(11'd0, UC_PUSHLIT, 35'h7_FFFF_FFFF, 1'b0, 32'd0, 32'h1100);
      checks++; if (sp_5a !== 11'd64) begin errors++; $display("FAIL of_sp got %0d want 64", sp_5a); end
      checks++; if (overflow_5a !== 1'b1) begin errors++; $display("FAIL of_flag got %b want 1", overflow_5a); end
      checks++; if (tos_5a !== 35'h1_0000_003F || nos_5a !== 35'h1_0000_003E) begin errors++; $display("FAIL of_tos_nos got %h/%h want 10000003f/10000003e", tos_5a, nos_5a); end
      op(11'd0, UC_PUSHNONE, 35'd0, 1'b0, 32'd0, 32'h1104);
      checks++; if (overflow_5a !== 1'b1) begin errors++; $display("FAIL of_sticky got %b want 1", overflow_5a); end
   endtask

   task automatic test_kill();
      op(11'd60, UC_PUSHNONE, 35'd0, 1'b0, 32'd0, 32'h3C);
      checks++; if (sp_5a !== 11'd4 || tos_5a !== 35'h1_0000_0003) begin errors++; $display("FAIL kill_pre got sp=%0d tos=%h want 4/100000003", sp_5a, tos_5a); end
      op(11'd1, UC_PUSHNONE, 35'd0, 1'b1, 32'h100, 32'h40);
      checks++; if (redirect_5a !== 1'b1 || redirect_target_5a !== 32'h100) begin errors++; $display("FAIL kill_redirect got %b/%h want 1/100", redirect_5a, redirect_target_5a); end
      checks++; if (sp_5a !== 11'd3 || tos_5a !== 35'h1_0000_0002 || nos_5a !== 35'h1_0000_0001) begin errors++; $display("FAIL kill_commit got sp=%0d tos=%h nos=%h want 3/100000002/100000001", sp_5a, tos_5a, nos_5a); end
      checks++; if (retired_pc_5a !== 32'h40) begin errors++; $display("FAIL kill_pc got %h want 40", retired_pc_5a); end
      op(11'd0, UC_PUSHALU, 35'h0BB, 1'b0, 32'd0, 32'h44);
      checks++; if (redirect_5a !== 1'b0 || sp_5a !== 11'd3 || tos_5a !== 35'h1_0000_0002) begin errors++; $display("FAIL shadow1 got rd=%b sp=%0d tos=%h want 0/3/100000002", redirect_5a, sp_5a, tos_5a); end
      checks++; if (retired_pc_5a !== 32'h40 || redirect_target_5a !== 32'h100) begin errors++; $display("FAIL shadow1_hold got pc=%h tgt=%h want 40/100", retired_pc_5a, redirect_target_5a); end
      op(11'd0, UC_PUSHALU, 35'h0CC, 1'b1, 32'h200, 32'h48);
      checks++; if (redirect_5a !== 1'b0 || redirect_target_5a !== 32'h100 || sp_5a !== 11'd3) begin errors++; $display("FAIL shadow2 got rd=%b tgt=%h sp=%0d want 0/100/3", redirect_5a, redirect_target_5a, sp_5a); end
      op(11'd0, UC_PUSHALU, 35'h0DD, 1'b0, 32'd0, 32'h4C);
      checks++; if (redirect_5a !== 1'b0 || sp_5a !== 11'd3) begin errors++; $display("FAIL shadow3 got rd=%b sp=%0d want 0/3", redirect_5a, sp_5a); end
      op(11'd0, UC_PUSHALU, 35'h0EE, 1'b0, 32'd0, 32'h50);
      checks++; if (sp_5a !== 11'd4 || tos_5a !== 35'h0EE || nos_5a !== 35'h1_0000_0002) begin errors++; $display("FAIL post_shadow got sp=%0d tos=%h nos=%h want 4/0ee/100000002", sp_5a, tos_5a, nos_5a); end
      checks++; if (retired_pc_5a !== 32'h50 || redirect_5a !== 1'b0) begin errors++; $display("FAIL post_shadow_pc got pc=%h rd=%b want 50/0", retired_pc_5a, redirect_5a); end
   endtask

   task automatic test_reset_mid();
      op(11'd0, UC_PUSHALU, 35'h011, 1'b0, 32'd0, 32'h54);
      op(11'd0, UC_PUSHALU, 35'h012, 1'b0, 32'd0, 32'h58);
      checks++; if (sp_5a !== 11'd6) begin errors++; $display("FAIL burst_sp got %0d want 6", sp_5a); end
      st__to_push_4a = 35'h013; c__to_push_4a = UC_PUSHALU; pc_4a = 32'h5C;
      #3;
      rst_b = 1'b0;
      #1;
      checks++; if (sp_5a !== 11'd0 || tos_5a !== 35'd0 || nos_5a !== 35'd0) begin errors++; $display("FAIL midrst_stack got sp=%0d tos=%h nos=%h want 0/0/0", sp_5a, tos_5a, nos_5a); end
      checks++; if (redirect_target_5a !== 32'd0 || retired_pc_5a !== 32'd0) begin errors++; $display("FAIL midrst_pc got tgt=%h pc=%h want 0/0", redirect_target_5a, retired_pc_5a); end
      checks++; if (underflow_5a !== 1'b0 || overflow_5a !== 1'b0 || redirect_5a !== 1'b0) begin errors++; $display("FAIL midrst_flags got uf=%b of=%b rd=%b want 0/0/0", underflow_5a, overflow_5a, redirect_5a); end
      @(posedge clk); #1;
      c__to_push_4a = UC_PUSHNONE;
      checks++; if (sp_5a !== 11'd0) begin errors++; $display("FAIL rst_held_sp got %0d want 0", sp_5a); end
      #3;
      rst_b = 1'b1;
      @(posedge clk); #1;
      op(11'd0, UC_PUSHNONE, 35'd0, 1'b0, 32'd0, 32'h60);
      checks++; if (sp_5a !== 11'd0 || tos_5a !== 35'd0 || nos_5a !== 35'd0) begin errors++; $display("FAIL empty_masked got sp=%0d tos=%h nos=%h want 0/0/0", sp_5a, tos_5a, nos_5a); end
      op(11'd0, UC_PUSHLIT, 35'h0EF, 1'b0, 32'd0, 32'h64);
      checks++; if (sp_5a !== 11'd1 || tos_5a !== 35'h0EF || nos_5a !== 35'd0) begin errors++; $display("FAIL after_rst_push got sp=%0d tos=%h nos=%h want 1/0ef/0", sp_5a, tos_5a, nos_5a); end
   endtask

   initial begin
      test_reset();
      test_push();
      test_pop_push();
      test_underflow();
      test_overflow();
      test_kill();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
